// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_if
// Description : Handshake bundle for the two-entry elastic pipeline stage.
//               Carries the upstream beat (in_*), the downstream beat
//               (out_*), the synchronous flush and the occupancy readout.
//               slave  : view of the stage itself.
//               master : view of the surrounding logic / testbench.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) ();

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport slave (
    input  flush,
    input  in_valid,
    output in_ready,
    input  in_ctrl,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_ctrl,
    output out_data,
    output occupancy
  );

  modport master (
    output flush,
    output in_valid,
    input  in_ready,
    output in_ctrl,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_ctrl,
    input  out_data,
    input  occupancy
  );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Two-entry elastic pipeline register (main + skid entry).
//               in_ready and out_valid are both registered, so there is no
//               combinational path from out_ready to in_ready. Full
//               throughput of one beat per cycle while out_ready is high.
//               The control field is zero whenever an entry holds a bubble.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous, active-high
//               bus        - pipe_stage_skid_if.slave (flush, in_*, out_*,
//                            occupancy)
//               stall_cnt  - [PIPE_STAGE_PERF_EN only] cycles with
//                            out_valid=1 and out_ready=0, saturating
//               bubble_cnt - [PIPE_STAGE_PERF_EN only] cycles with
//                            out_valid=0 and flush=0, saturating
// Options     : define PIPE_STAGE_PERF_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_stage_skid_if.slave      bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic accept;
  logic consume;

  assign accept  = bus.in_valid & in_ready_q;
  assign consume = out_valid_q & bus.out_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (bus.flush) begin
      // Kill everything held, including a beat accepted this same cycle.
      // Data is left in place; only the control fields become bubbles.
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
            state_d     = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end else if (accept) begin
            // Downstream stalled: park the new beat behind the head.
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
            state_d     = S_TWO;
          end else if (consume) begin
            main_ctrl_d = '0;
            state_d     = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a consume can happen.
          if (consume) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            state_d     = S_ONE;
          end
        end
        default: begin
          state_d     = S_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end

    // Registered handshake outputs are the decode of the next state.
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_data  = main_data_q;
  assign bus.occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters, cleared only by reset
  // --------------------------------------------------------------------------
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid_q && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (!out_valid_q && !bus.flush && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. Each accepted beat
//               is pushed into a scoreboard queue; each consumed beat is
//               popped and compared. Occupancy, out_valid, in_ready and the
//               bubble control field are checked against the queue depth
//               every cycle. Counter checks are built when
//               PIPE_STAGE_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 128;
  localparam int BEAT_W = CTRL_W + DATA_W;

  logic clk;
  logic reset;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [BEAT_W-1:0] sb[$];

  task automatic check(input string tag, input logic [BEAT_W-1:0] obs,
                       input logic [BEAT_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Outputs are checked
  // against the model, then the scoreboard is updated for the coming edge.
  task automatic step(input logic v, input logic [CTRL_W-1:0] c,
                      input logic [DATA_W-1:0] d, input logic ordy,
                      input logic fl);
    int n;
    logic acc;
    logic cons;
    logic [BEAT_W-1:0] head;
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    n = sb.size();
    check("occupancy", BEAT_W'(bus.occupancy), BEAT_W'(n));
    check("out_valid", BEAT_W'(bus.out_valid), BEAT_W'(n != 0));
    check("in_ready", BEAT_W'(bus.in_ready), BEAT_W'(n < 2));
    if (!bus.out_valid) check("bubble_ctrl", BEAT_W'(bus.out_ctrl), '0);
    acc  = v && (n < 2);
    cons = ordy && (n != 0);
    if (cons) begin
      head = sb.pop_front();
      check("beat", {bus.out_ctrl, bus.out_data}, head);
    end
    if (fl) sb.delete();
    else if (acc) sb.push_back({c, d});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    reset         = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", BEAT_W'(bus.in_ready), '0);
    check("rst_out_valid", BEAT_W'(bus.out_valid), '0);
    check("rst_occupancy", BEAT_W'(bus.occupancy), '0);
    check("rst_out_ctrl", BEAT_W'(bus.out_ctrl), '0);
    check("rst_out_data", BEAT_W'(bus.out_data), '0);
    reset = 1'b0;
    #1;
    check("rel_in_ready_low", BEAT_W'(bus.in_ready), '0);
    @(posedge clk);
    @(negedge clk);
    check("rel_in_ready_high", BEAT_W'(bus.in_ready), BEAT_W'(1));

    // Streaming A, B, C with out_ready held high
    step(1'b1, 8'hA1, 128'h11, 1'b1, 1'b0);
    step(1'b1, 8'hB2, 128'h22, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 128'h33, 1'b1, 1'b0);
    repeat (2) step(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

    // Backpressure: fill both entries, then drain
    step(1'b1, 8'h1F, 128'h11, 1'b0, 1'b0);
    step(1'b1, 8'h2F, 128'h22, 1'b0, 1'b0);
    step(1'b1, 8'h3F, 128'h99, 1'b0, 1'b0); // refused: stage full
    repeat (3) step(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

    // Flush while full with a beat offered
    step(1'b1, 8'h1E, 128'h11, 1'b0, 1'b0);
    step(1'b1, 8'h2E, 128'h22, 1'b0, 1'b0);
    step(1'b1, 8'h3E, 128'h33, 1'b0, 1'b1);
    repeat (2) step(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

    // Flush in ONE with accept and consume in the same cycle
    step(1'b1, 8'h4D, 128'h44, 1'b0, 1'b0);
    step(1'b1, 8'h5D, 128'h55, 1'b1, 1'b1);
    step(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    begin
      logic [31:0] b0;
      logic [31:0] s0;
      b0 = bubble_cnt;
      repeat (3) step(1'b0, 8'h00, 128'h0, 1'b0, 1'b0);
      check("bubble_cnt", BEAT_W'(bubble_cnt), BEAT_W'(b0 + 32'd3));
      step(1'b1, 8'h6C, 128'h66, 1'b0, 1'b0);
      s0 = stall_cnt;
      repeat (5) step(1'b0, 8'h00, 128'h0, 1'b0, 1'b0);
      check("stall_cnt", BEAT_W'(stall_cnt), BEAT_W'(s0 + 32'd5));
      repeat (2) step(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);
    end
`endif

    // Asynchronous reset between edges while holding one beat
    step(1'b1, 8'h42, 128'h42, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", BEAT_W'(bus.out_valid), '0);
    check("arst_out_ctrl", BEAT_W'(bus.out_ctrl), '0);
    check("arst_in_ready", BEAT_W'(bus.in_ready), '0);
    check("arst_occupancy", BEAT_W'(bus.occupancy), '0);
    sb.delete();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("arst_rel_in_ready", BEAT_W'(bus.in_ready), BEAT_W'(1));
    check("arst_rel_out_valid", BEAT_W'(bus.out_valid), '0);
    @(negedge clk);

    // Random valid/ready/flush traffic
    for (int i = 0; i < 10000; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 9) < 6), CTRL_W'($urandom), rd,
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 63) == 0));
    end
    repeat (4) step(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter CTRL_W, default 8: width of the control field, which is zeroed whenever the stage holds a bubble.
REQ-002 Parameter DATA_W, default 128: width of the data payload (operands, immediates, PCs, register addresses).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous kill of all held beats.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage can accept a beat; registered.
REQ-008 in_ctrl  input  CTRL_W  upstream control field.
REQ-009 in_data  input  DATA_W  upstream data payload.
REQ-010 out_valid  output  1  downstream beat present; registered.
REQ-011 out_ready  input  1  downstream accepts a beat.
REQ-012 out_ctrl  output  CTRL_W  control field of the head beat.
REQ-013 out_data  output  DATA_W  data payload of the head beat.
REQ-014 occupancy  output  2  number of held beats (0, 1 or 2).

Function
REQ-015 The stage SHALL be a two-entry elastic register: a main entry (drives the outputs) and a skid entry, with states EMPTY, ONE and TWO.
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both high; a beat SHALL be consumed when out_valid and out_ready are both high.
REQ-017 In EMPTY, an accept SHALL load the main entry and move the state to ONE; out_valid SHALL be high in the next cycle (1-cycle latency).
REQ-018 In ONE, accept plus consume SHALL load the new beat into the main entry and stay in ONE.
REQ-019 In ONE, accept with no consume SHALL load the new beat into the skid entry and move to TWO.
REQ-020 In ONE, consume with no accept SHALL move to EMPTY.
REQ-021 In TWO, a consume SHALL move the skid entry into the main entry and move to ONE.
REQ-022 In TWO, no accept is possible.
REQ-023 in_ready SHALL equal NOT(state==TWO) as registered state, so in_ready never depends combinationally on out_ready.
REQ-024 Beat order SHALL be preserved, and sustained throughput SHALL be one beat per cycle while out_ready is held high.
REQ-025 When out_valid is low, out_ctrl SHALL be all zeros; out_data SHALL retain its last value.
REQ-026 A beat SHALL never be duplicated or dropped, except by flush.
REQ-027 occupancy SHALL read 0, 1 or 2 for EMPTY, ONE or TWO.
REQ-028 flush high at a clock edge SHALL move the stage to EMPTY and zero the control field of both entries.
REQ-029 flush SHALL take priority over a simultaneous accept and consume; the accepted beat is discarded.
REQ-030 After a flush, in_ready SHALL be 1 in the following cycle.
REQ-031 An out_ready-only handshake during the flush cycle SHALL still count as consumed by downstream.

Reset
REQ-032 reset SHALL asynchronously force state EMPTY, in_ready 0, out_valid 0, out_ctrl 0, out_data 0, occupancy 0, and both entries' control and data to zero.
REQ-033 in_ready SHALL rise to 1 on the first clock edge after reset deasserts.
REQ-034 Reset asserted mid-transfer SHALL discard all held beats with no partial outputs.

Configuration
REQ-035 With macro PIPE_STAGE_PERF_EN defined, the block SHALL add output stall_cnt (32 bits), which increments on each cycle with out_valid=1 and out_ready=0.
REQ-036 With macro PIPE_STAGE_PERF_EN defined, the block SHALL add output bubble_cnt (32 bits), which increments on each cycle with out_valid=0 and flush=0.
REQ-037 stall_cnt and bubble_cnt SHALL saturate at 0xFFFFFFFF and SHALL clear only on reset.
REQ-038 Without PIPE_STAGE_PERF_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-039 Reset then stream: push beats A=0x11, B=0x22, C=0x33 with out_ready=1 -> outputs A, B, C on consecutive cycles, first output 1 cycle after accept, occupancy stays 1.
REQ-040 Backpressure: out_ready=0, push 0x11 and 0x22 -> occupancy 2, in_ready=0; raise out_ready -> 0x11 then 0x22 delivered, in_ready back to 1 one cycle after the first consume.
REQ-041 Flush in TWO with in_valid=1 (0x33) -> next cycle out_valid=0, out_ctrl=0, occupancy 0, 0x33 never appears at the output.
REQ-042 Asynchronous reset pulse between clock edges in state ONE -> out_valid and out_ctrl go to 0 immediately; in_ready=1 on the first edge after release.
REQ-043 Random valid/ready toggling for 10000 cycles with a scoreboard -> no loss, duplication or reorder; out_ctrl=0 whenever out_valid=0.
REQ-044 PIPE_STAGE_PERF_EN: hold out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5; 3 idle cycles -> bubble_cnt=3.
